// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: controller state type and default timing constants
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
  localparam int TICK_DIV_DEF = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, debounces it and emits a one-cycle press pulse
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, press_q, flip;
  // flip the level once the synced value has disagreed for DB_CYCLES cycles in a row
  always_comb begin
    flip = (sync_q[1] != level_q) && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
  end
  // synchronizer, debounce state and registered rising-edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced run/pause/clear control with a 1 Hz run strobe for the timer
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_clr,
  output logic run,
  output logic clr,
  output logic running
);
  localparam int PW = $clog2(TICK_DIV);
  logic start_p, clr_p, wrap;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic run_q, run_d, clr_q, running_q;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_start), .level(), .press(start_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clr), .level(), .press(clr_p)
  );
  // next state and prescaler; clear overrides start, and a pause landing on the last
  // count of a second holds there so the strobe fires right after resuming
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    run_d = 1'b0;
    wrap = presc_q == PW'(TICK_DIV - 1);
    if (clr_p) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (state_q == RUNNING) begin
      state_d = start_p ? PAUSED : RUNNING;
      presc_d = wrap ? (start_p ? presc_q : '0) : presc_q + 1'b1;
      run_d = wrap && !start_p;
    end else if (start_p) begin
      state_d = RUNNING;
      presc_d = (state_q == IDLE) ? '0 : presc_q;
    end
  end
  // FSM, prescaler and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      run_q <= 1'b0;
      clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      run_q <= run_d;
      clr_q <= clr_p;
      running_q <= state_d == RUNNING;
    end
  end
  assign run = run_q;
  assign clr = clr_q;
  assign running = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario and randomized checks of stopwatch_ctrl against a reference model
module tb_stopwatch_ctrl;
  localparam int TICK = 10;
  localparam int DB = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  logic clk = 1'b0, rst_n = 1'b0, btn_start = 1'b0, btn_clr = 1'b0;
  logic run, clr, running;
  int checks = 0, errors = 0;
  bit m_s1[2], m_s2[2], m_lvl[2], m_fa[2], m_fb[2];
  bit m_hist[2][DB];
  int m_mode, m_acc;
  bit m_run, m_clr, m_running;

  stopwatch_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clr(btn_clr),
    .run(run), .clr(clr), .running(running)
  );

  always #5 clk = ~clk;

  // Reference: a button is accepted once the last DB synced samples all disagree with
  // the accepted level; the press reaches the controller two cycles later. m_acc counts
  // running cycles within the current second.
  task automatic model(input bit bs, input bit bc, input bit rn);
    bit raw[2];
    bit sp, cp, diff, seen;
    raw[0] = bs;
    raw[1] = bc;
    if (!rn) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_fa[b] = 0; m_fb[b] = 0;
        for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
      end
      m_mode = M_IDLE; m_acc = 0; m_run = 0; m_clr = 0; m_running = 0;
      return;
    end
    sp = m_fb[0];
    cp = m_fb[1];
    for (int b = 0; b < 2; b++) begin
      seen = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
      m_hist[b][0] = seen;
      diff = 1;
      for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) diff = 0;
      m_fb[b] = m_fa[b];
      m_fa[b] = 0;
      if (diff) begin
        m_lvl[b] = !m_lvl[b];
        m_fa[b] = m_lvl[b];
      end
    end
    m_run = 0;
    m_clr = 0;
    if (cp) begin
      m_mode = M_IDLE; m_acc = 0; m_clr = 1;
    end else if (m_mode == M_RUN) begin
      m_acc++;
      if (sp) begin
        m_mode = M_PAUSE;
        if (m_acc == TICK) m_acc = TICK - 1;
      end else if (m_acc == TICK) begin
        m_run = 1; m_acc = 0;
      end
    end else if (sp) begin
      if (m_mode == M_IDLE) m_acc = 0;
      m_mode = M_RUN;
    end
    m_running = (m_mode == M_RUN);
  endtask

  task automatic tick(input bit bs, input bit bc, input bit rn);
    @(negedge clk);
    btn_start = bs; btn_clr = bc; rst_n = rn;
    @(posedge clk);
    model(bs, bc, rn);
    #1;
  endtask

  task automatic rst_seq();
    tick(0, 0, 0);
    tick(0, 0, 0);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 25; e++) begin
      tick(0, 0, e >= 5);
      checks++;
      if ({run, clr, running} !== 3'b000) begin
        errors++;
        $display("FAIL reset e=%0d run/clr/running got %b%b%b expected 000", e, run, clr, running);
      end
    end
  endtask

  task automatic test_start();
    bit er, eg;
    rst_seq();
    for (int e = 0; e < 40; e++) begin
      tick(e < 10, 0, 1);
      eg = e >= 7;
      er = (e == 17) || (e == 27) || (e == 37);
      checks++;
      if ({run, clr, running} !== {er, 1'b0, eg}) begin
        errors++;
        $display("FAIL start e=%0d run/clr/running got %b%b%b expected %b0%b", e, run, clr, running, er, eg);
      end
    end
  endtask

  task automatic test_glitch();
    rst_seq();
    for (int e = 0; e < 30; e++) begin
      tick(e < 3, e == 6 || e == 7, 1);
      checks++;
      if ({run, clr, running} !== 3'b000) begin
        errors++;
        $display("FAIL glitch e=%0d run/clr/running got %b%b%b expected 000", e, run, clr, running);
      end
    end
  endtask

  task automatic test_pause();
    bit er, eg;
    rst_seq();
    for (int e = 0; e < 60; e++) begin
      tick(e < 5 || (e >= 16 && e < 21) || (e >= 30 && e < 35), 0, 1);
      eg = (e >= 7 && e < 23) || e >= 37;
      er = (e == 17) || (e == 41) || (e == 51);
      checks++;
      if ({run, clr, running} !== {er, 1'b0, eg}) begin
        errors++;
        $display("FAIL pause e=%0d run/clr/running got %b%b%b expected %b0%b", e, run, clr, running, er, eg);
      end
    end
  endtask

  task automatic test_conflict();
    bit er, ec, eg;
    rst_seq();
    for (int e = 0; e < 40; e++) begin
      tick(e < 5 || (e >= 12 && e < 17), e >= 12 && e < 17, 1);
      eg = e >= 7 && e < 19;
      er = e == 17;
      ec = e == 19;
      checks++;
      if ({run, clr, running} !== {er, ec, eg}) begin
        errors++;
        $display("FAIL conflict e=%0d run/clr/running got %b%b%b expected %b%b%b", e, run, clr, running, er, ec, eg);
      end
    end
  endtask

  task automatic test_midreset();
    bit er, eg;
    rst_seq();
    for (int e = 0; e < 60; e++) begin
      tick(e < 5 || (e >= 37 && e < 42), 0, e != 15 && e != 16);
      eg = (e >= 7 && e < 15) || e >= 44;
      er = e == 54;
      checks++;
      if ({run, clr, running} !== {er, 1'b0, eg}) begin
        errors++;
        $display("FAIL midreset e=%0d run/clr/running got %b%b%b expected %b0%b", e, run, clr, running, er, eg);
      end
    end
  endtask

  task automatic test_random();
    int ls = 0, lc = 0;
    bit bs = 0, bc = 0, rn;
    rst_seq();
    for (int i = 0; i < 3000; i++) begin
      if (ls == 0) begin bs = !bs; ls = $urandom_range(1, 9); end
      if (lc == 0) begin bc = !bc; lc = bc ? $urandom_range(1, 7) : $urandom_range(5, 60); end
      ls--;
      lc--;
      rn = $urandom_range(0, 399) != 0;
      tick(bs, bc, rn);
      checks++;
      if ({run, clr, running} !== {m_run, m_clr, m_running}) begin
        errors++;
        $display("FAIL random i=%0d run/clr/running got %b%b%b expected %b%b%b", i, run, clr, running, m_run, m_clr, m_running);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_pause();
    test_conflict();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
